ste_snd_fifo: RTL and testbench

- DMA-sound consumer at the far end of the MCU sound DMA handshake (SREQ/SLOAD_N).
- Requests words from the MCU, latches them from the data bus on each load strobe, and buffers them in a 4-word FIFO.
- Replays the buffered words as signed 8-bit left/right samples at a programmable rate.
- Sits beside the shifter; its outputs feed the audio mixer/DAC.

---
 rtl/ste_snd_pkg.sv | 35 +++
 rtl/snd_word_fifo.sv | 80 ++++++++
 rtl/ste_snd_fifo.sv | 171 +++++++++++++++++
 tb/tb_ste_snd_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ste_snd_pkg.sv
// Shared constants and types for the DMA sound FIFO.
// Rate encodings, default prescaler divide and sample width.
package ste_snd_pkg;

    localparam logic [1:0] RATE_6K25 = 2'b00;
    localparam logic [1:0] RATE_12K5 = 2'b01;
    localparam logic [1:0] RATE_25K  = 2'b10;
    localparam logic [1:0] RATE_50K  = 2'b11;

    localparam int CLK_DIV_50K_DEF = 640;
    localparam int SAMPLE_W        = 8;
    localparam int WORD_W          = 16;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    // clk32 cycles between sample ticks for a given rate code
    function automatic int unsigned tick_period(
        input int unsigned div50k,
        input logic [1:0]  r
    );
        int unsigned p;
        case (r)
            RATE_6K25: p = div50k * 8;
            RATE_12K5: p = div50k * 4;
            RATE_25K:  p = div50k * 2;
            RATE_50K:  p = div50k;
            default:   p = div50k;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/snd_word_fifo.sv
// Synchronous DEPTH x 16 word FIFO for the sound path.
// A pop in the same cycle frees a slot, so a push at full is accepted.
module snd_word_fifo
    import ste_snd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WORD_W-1:0]       wdata,
    output logic [WORD_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]  count_next,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rptr_q;
    logic [AW-1:0]     rptr_d;
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     wptr_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              do_push;
    logic              do_pop;

    // Pop is resolved before push; clear overrides both
    always_comb begin
        do_pop  = pop & (count_q != '0) & ~clr;
        do_push = push & ((count_q != CW'(DEPTH)) | do_pop) & ~clr;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (clr) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (do_push) begin
                wptr_d = wptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign rdata      = mem_q[rptr_q];
    assign count_next = count_d;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/ste_snd_fifo.sv
// DMA sound consumer: requests and buffers words from the MCU,
// replays them as signed 8-bit L/R samples at a programmable rate.
module ste_snd_fifo
    import ste_snd_pkg::*;
#(
    parameter int CLK_DIV_50K = CLK_DIV_50K_DEF,
    parameter int DEPTH       = 4
) (
    input  logic                clk32,
    input  logic                resb,
    input  logic                snd_en,
    input  logic                stereo,
    input  logic [1:0]          rate,
    input  logic [WORD_W-1:0]   din,
    input  logic                sload_n,
    output logic                sreq,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right,
    output logic                sample_stb,
    output logic                underrun,
    output logic                overrun
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(CLK_DIV_50K * 8);

    logic                sload_prev_q;
    logic                sload_prev_d;
    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_d;
    phase_e              phase_q;
    phase_e              phase_d;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] left_d;
    logic [SAMPLE_W-1:0] right_q;
    logic [SAMPLE_W-1:0] right_d;
    logic                stb_q;
    logic                stb_d;
    logic                und_q;
    logic                und_d;
    logic                ovr_q;
    logic                ovr_d;
    logic                sreq_q;
    logic                sreq_d;

    logic                load;
    logic                tick;
    logic                have;
    logic                pop;
    logic                fifo_clr;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_rdata;
    logic [CW-1:0]       count_next;
    logic [PW-1:0]       reload;
    logic [SAMPLE_W-1:0] hi_byte;
    logic [SAMPLE_W-1:0] lo_byte;

    assign fifo_clr = ~snd_en;
    assign hi_byte  = fifo_rdata[WORD_W-1 -: SAMPLE_W];
    assign lo_byte  = fifo_rdata[SAMPLE_W-1:0];

    snd_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk32),
        .rst_n      (resb),
        .clr        (fifo_clr),
        .push       (load),
        .pop        (pop),
        .wdata      (din),
        .rdata      (fifo_rdata),
        .count_next (count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Prescaler reload value for the currently selected rate
    always_comb begin
        reload = PW'(tick_period(CLK_DIV_50K, rate) - 1);
    end

    // Strobe edge detect, tick generation, pop decision, prescaler
    always_comb begin
        sload_prev_d = sload_n;
        load         = snd_en & ~sload_n & sload_prev_q;
        tick         = snd_en & (presc_q == '0);
        have         = ~fifo_empty;
        pop          = 1'b0;
        if (tick && have) begin
            pop = stereo | (phase_q == PH_LO);
        end
        presc_d = presc_q - PW'(1);
        if (!snd_en || tick) begin
            presc_d = reload;
        end
    end

    // Sample output, byte phase and error pulses
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        phase_d = phase_q;
        stb_d   = 1'b0;
        und_d   = 1'b0;
        ovr_d   = load & fifo_full & ~pop;
        if (tick) begin
            if (!have) begin
                und_d = 1'b1;
            end else if (stereo) begin
                left_d  = hi_byte;
                right_d = lo_byte;
                phase_d = PH_HI;
                stb_d   = 1'b1;
            end else if (phase_q == PH_HI) begin
                left_d  = hi_byte;
                right_d = hi_byte;
                phase_d = PH_LO;
                stb_d   = 1'b1;
            end else begin
                left_d  = lo_byte;
                right_d = lo_byte;
                phase_d = PH_HI;
                stb_d   = 1'b1;
            end
        end
        if (!snd_en) begin
            left_d  = '0;
            right_d = '0;
            phase_d = PH_HI;
        end
    end

    // Request while at least two free slots remain after this cycle
    always_comb begin
        sreq_d = snd_en & (count_next <= CW'(DEPTH - 2));
    end

    // State registers
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            sload_prev_q <= 1'b1;
            presc_q      <= '0;
            phase_q      <= PH_HI;
            left_q       <= '0;
            right_q      <= '0;
            stb_q        <= 1'b0;
            und_q        <= 1'b0;
            ovr_q        <= 1'b0;
            sreq_q       <= 1'b0;
        end else begin
            sload_prev_q <= sload_prev_d;
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            left_q       <= left_d;
            right_q      <= right_d;
            stb_q        <= stb_d;
            und_q        <= und_d;
            ovr_q        <= ovr_d;
            sreq_q       <= sreq_d;
        end
    end

    assign sreq       = sreq_q;
    assign left       = left_q;
    assign right      = right_q;
    assign sample_stb = stb_q;
    assign underrun   = und_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_ste_snd_fifo.sv
// Directed bench for ste_snd_fifo: handshake, playback order,
// mono split, overrun/underrun, flush, held strobe, async reset.
module tb_ste_snd_fifo;

    logic        clk32;
    logic        resb;
    logic        snd_en;
    logic        stereo;
    logic [1:0]  rate;
    logic [15:0] din;
    logic        sload_n;
    logic        sreq;
    logic [7:0]  left;
    logic [7:0]  right;
    logic        sample_stb;
    logic        underrun;
    logic        overrun;

    int n_chk = 0;
    int n_err = 0;
    int n;
    int s;
    int u;

    logic [15:0] wds [4];
    logic [7:0]  exp_b [4];

    ste_snd_fifo dut (
        .clk32      (clk32),
        .resb       (resb),
        .snd_en     (snd_en),
        .stereo     (stereo),
        .rate       (rate),
        .din        (din),
        .sload_n    (sload_n),
        .sreq       (sreq),
        .left       (left),
        .right      (right),
        .sample_stb (sample_stb),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    task automatic load_start(input logic [15:0] w);
        din     = w;
        sload_n = 1'b0;
        step();
    endtask

    task automatic load_end();
        sload_n = 1'b1;
        step();
    endtask

    task automatic wait_stb(input int lim, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!sample_stb && cnt < lim);
        if (!sample_stb) check("stb_wait", 0, 1);
    endtask

    task automatic wait_und(input int lim, output int cnt, output int stbs);
        cnt  = 0;
        stbs = 0;
        do begin
            step();
            cnt++;
            stbs += int'(sample_stb);
        end while (!underrun && cnt < lim);
        if (!underrun) check("und_wait", 0, 1);
    endtask

    initial begin
        resb    = 1'b0;
        snd_en  = 1'b0;
        stereo  = 1'b1;
        rate    = 2'b11;
        din     = '0;
        sload_n = 1'b1;
        repeat (3) step();
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_sreq", sreq, 0);
        check("rst_stb", sample_stb, 0);
        check("rst_und", underrun, 0);
        check("rst_ovr", overrun, 0);

        resb = 1'b1;
        step();
        step();
        check("sreq_pre_en", sreq, 0);
        snd_en = 1'b1;
        step();
        check("sreq_en", sreq, 1);
        s = 0;
        u = 0;
        for (int k = 2; k <= 639; k++) begin
            step();
            s += int'(sample_stb);
            u += int'(underrun);
        end
        check("quiet_stb", s, 0);
        check("quiet_und", u, 0);
        step();
        check("first_tick_und", underrun, 1);
        check("first_tick_left", left, 0);

        wds[0] = 16'h7F80;
        wds[1] = 16'h0102;
        wds[2] = 16'hFE03;
        wds[3] = 16'h1020;
        load_start(wds[0]);
        check("sreq_l1", sreq, 1);
        load_end();
        load_start(wds[1]);
        check("sreq_l2", sreq, 1);
        load_end();
        load_start(wds[2]);
        check("sreq_l3", sreq, 0);
        load_end();
        load_start(wds[3]);
        check("sreq_l4", sreq, 0);
        load_end();
        wait_stb(700, n);
        check("st0_l", left, 8'h7F);
        check("st0_r", right, 8'h80);
        wait_stb(700, n);
        check("st1_per", n, 640);
        check("st1_l", left, 8'h01);
        check("st1_r", right, 8'h02);
        wait_stb(700, n);
        check("st2_per", n, 640);
        check("st2_l", left, 8'hFE);
        check("st2_r", right, 8'h03);
        wait_stb(700, n);
        check("st3_per", n, 640);
        check("st3_l", left, 8'h10);
        check("st3_r", right, 8'h20);

        load_start(16'h1111);
        load_end();
        load_start(16'h2222);
        load_end();
        load_start(16'h3333);
        load_end();
        load_start(16'h4444);
        load_end();
        check("full_sreq", sreq, 0);
        load_start(16'hDEAD);
        check("ovr_pulse", overrun, 1);
        load_end();
        check("ovr_once", overrun, 0);
        wait_stb(700, n);
        check("ov0_l", left, 8'h11);
        check("ov0_r", right, 8'h11);
        load_start(16'h5555);
        load_end();
        repeat (637) step();
        load_start(16'h6666);
        check("coin_ovr", overrun, 0);
        check("coin_stb", sample_stb, 1);
        check("coin_l", left, 8'h22);
        check("coin_r", right, 8'h22);
        load_end();
        exp_b[0] = 8'h33;
        exp_b[1] = 8'h44;
        exp_b[2] = 8'h55;
        exp_b[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            wait_stb(700, n);
            check($sformatf("seq%0d_l", i), left, exp_b[i]);
            check($sformatf("seq%0d_r", i), right, exp_b[i]);
        end

        wait_und(700, n, s);
        check("und_per", n, 640);
        check("und_nostb", s, 0);
        check("und_hold_l", left, 8'h66);
        check("und_hold_r", right, 8'h66);

        rate   = 2'b00;
        stereo = 1'b0;
        snd_en = 1'b0;
        step();
        check("dis_left", left, 0);
        snd_en = 1'b1;
        load_start(16'hAB12);
        load_end();
        wait_stb(5200, n);
        check("mono0_l", left, 8'hAB);
        check("mono0_r", right, 8'hAB);
        wait_stb(5200, n);
        check("mono1_per", n, 5120);
        check("mono1_l", left, 8'h12);
        check("mono1_r", right, 8'h12);
        check("mono_cnt", dut.u_fifo.count_q, 0);

        snd_en = 1'b0;
        rate   = 2'b11;
        stereo = 1'b1;
        step();
        snd_en = 1'b1;
        load_start(16'h0A0B);
        load_end();
        load_start(16'h0C0D);
        load_end();
        load_start(16'h0E0F);
        load_end();
        wait_stb(700, n);
        check("mid_l", left, 8'h0A);
        check("mid_r", right, 8'h0B);
        load_start(16'h1213);
        load_end();
        check("mid_cnt", dut.u_fifo.count_q, 3);
        snd_en = 1'b0;
        step();
        check("flush_sreq", sreq, 0);
        check("flush_l", left, 0);
        check("flush_r", right, 0);
        check("flush_cnt", dut.u_fifo.count_q, 0);
        snd_en = 1'b1;
        wait_und(700, n, s);
        check("reen_per", n, 640);
        check("reen_nostb", s, 0);
        load_start(16'h3344);
        load_end();
        wait_stb(700, n);
        check("reen_l", left, 8'h33);
        check("reen_r", right, 8'h44);

        din     = 16'h5A5A;
        sload_n = 1'b0;
        repeat (10) step();
        sload_n = 1'b1;
        step();
        check("hold_cnt", dut.u_fifo.count_q, 1);
        wait_stb(700, n);
        check("hold_l", left, 8'h5A);
        check("hold_r", right, 8'h5A);

        load_start(16'h7788);
        load_end();
        #2;
        resb = 1'b0;
        #1;
        check("arst_l", left, 0);
        check("arst_r", right, 0);
        check("arst_sreq", sreq, 0);
        check("arst_cnt", dut.u_fifo.count_q, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
